// File: rtl/opcol_pkg.sv
// Shared types for the operand collector: FSM state, request kind and the
// per-request tag that travels alongside the memory read latency.
package opcol_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SER1 = 2'd1,
        ST_SER2 = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_PAR   = 2'd0,
        K_SER_A = 2'd1,
        K_SER_B = 2'd2
    } kind_t;

    // The address rides in a parallel array so the record stays independent of AW.
    typedef struct packed {
        logic  vld;
        kind_t kind;
        logic  bank;
        logic  swap;
    } tag_t;

endpackage

// File: rtl/opcol_fifo.sv
// Operand-pair FIFO toward the ALU. A push is accepted while full only when
// a pop happens in the same cycle; the head output holds its last value when empty.
module opcol_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_full
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [W-1:0]  r_last;
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [PW:0]   r_count;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;

    assign w_empty = (r_count == '0);
    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign w_pop   = i_pop & ~w_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_valid = ~w_empty;
    assign o_data  = w_empty ? r_last : r_mem[r_rd];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_last  <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + PW'(1);
            end
            if (w_pop) begin
                r_rd   <= r_rd + PW'(1);
                r_last <= r_mem[r_rd];
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (PW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/operand_collector.sv
// Pairs bank A/B read data into (op_a, op_b) for the ALU, undoing the odd-address bank swap.
// Optional macro OPCOL_CONFLICT_CNT_EN adds o_conflict_cnt (saturating count of SER_B requests).
module operand_collector
    import opcol_pkg::*;
#(
    parameter int DW      = 8,
    parameter int AW      = 4,
    parameter int MEM_LAT = 1,
    parameter int DEPTH   = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_mar_load_a,
    input  logic [AW-1:0] i_mar_in_a,
    input  logic          i_mar_load_b,
    input  logic [AW-1:0] i_mar_in_b,
    input  logic          i_mem_oe_a,
    input  logic          i_mem_oe_b,
    input  logic          i_stall,
    input  logic [DW-1:0] i_rd_data_a,
    input  logic [DW-1:0] i_rd_data_b,
    input  logic          i_ops_ready,
    output logic          o_ops_valid,
    output logic [DW-1:0] o_op_a,
    output logic [DW-1:0] o_op_b,
    output logic [AW-1:0] o_op_addr,
    output logic          o_overflow
`ifdef OPCOL_CONFLICT_CNT_EN
    ,
    output logic [7:0]    o_conflict_cnt
`endif
);
    localparam int PW = AW + 2*DW;

    state_t        r_state;
    tag_t          r_tag      [MEM_LAT];
    logic [AW-1:0] r_tag_addr [MEM_LAT];
    logic          r_pvld;
    logic [PW-1:0] r_pair;
    logic          r_hold_vld;
    logic [DW-1:0] r_hold_data;
    logic [AW-1:0] r_hold_addr;
    logic          r_overflow;

    logic          w_both;
    logic          w_one;
    logic          w_swap;
    logic          w_ser_b;
    logic [AW-1:0] w_b_inc;
    logic [AW-1:0] w_req_addr;
    tag_t          w_exit;
    logic [AW-1:0] w_exit_addr;
    logic [DW-1:0] w_sel;
    logic [PW-1:0] w_head;
    logic          w_full;
    logic          w_pop;
    logic          w_unused;

    assign w_both     = i_mem_oe_a & i_mem_oe_b;
    assign w_one      = i_mem_oe_a ^ i_mem_oe_b;
    assign w_b_inc    = i_mar_in_b + AW'(1);
    assign w_swap     = (w_b_inc == i_mar_in_a);
    assign w_req_addr = (i_mem_oe_b && (!i_mem_oe_a || w_swap)) ? i_mar_in_b : i_mar_in_a;
    assign w_ser_b    = (r_state == ST_SER1) && w_one;
    // Addresses are taken straight from the MAR inputs at request time.
    assign w_unused   = ^{i_mar_load_a, i_mar_load_b, i_stall, w_ser_b};

    // Classification FSM and tag delay line share one register block.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            for (int i = 0; i < MEM_LAT; i++) begin
                r_tag[i]      <= '0;
                r_tag_addr[i] <= '0;
            end
        end else begin
            for (int i = 1; i < MEM_LAT; i++) begin
                r_tag[i]      <= r_tag[i-1];
                r_tag_addr[i] <= r_tag_addr[i-1];
            end
            r_tag[0]      <= '0;
            r_tag_addr[0] <= w_req_addr;
            case (r_state)
                ST_IDLE: begin
                    if (w_both) begin
                        r_tag[0] <= '{vld: 1'b1, kind: K_PAR, bank: 1'b0, swap: w_swap};
                    end else if (w_one) begin
                        r_tag[0] <= '{vld: 1'b1, kind: K_SER_A, bank: i_mem_oe_b, swap: 1'b0};
                        r_state  <= ST_SER1;
                    end
                end
                ST_SER1: begin
                    if (w_both) begin
                        r_state <= ST_IDLE;
                    end else if (w_one) begin
                        r_tag[0] <= '{vld: 1'b1, kind: K_SER_B, bank: i_mem_oe_b, swap: 1'b0};
                        r_state  <= ST_SER2;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_exit      = r_tag[MEM_LAT-1];
    assign w_exit_addr = r_tag_addr[MEM_LAT-1];
    assign w_sel       = w_exit.bank ? i_rd_data_b : i_rd_data_a;

    // Pair layout is {addr, op_b, op_a}.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pvld      <= 1'b0;
            r_pair      <= '0;
            r_hold_vld  <= 1'b0;
            r_hold_data <= '0;
            r_hold_addr <= '0;
        end else begin
            r_pvld <= 1'b0;
            if (w_exit.vld) begin
                case (w_exit.kind)
                    K_PAR: begin
                        r_pvld <= 1'b1;
                        r_pair <= w_exit.swap ? {w_exit_addr, i_rd_data_a, i_rd_data_b}
                                              : {w_exit_addr, i_rd_data_b, i_rd_data_a};
                    end
                    K_SER_A: begin
                        r_hold_vld  <= 1'b1;
                        r_hold_data <= w_sel;
                        r_hold_addr <= w_exit_addr;
                    end
                    K_SER_B: begin
                        r_pvld     <= r_hold_vld;
                        r_pair     <= {r_hold_addr, w_sel, r_hold_data};
                        r_hold_vld <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_pop = o_ops_valid & i_ops_ready;

    opcol_fifo #(
        .W     (PW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (r_pvld),
        .i_data  (r_pair),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_valid (o_ops_valid),
        .o_full  (w_full)
    );

    assign {o_op_addr, o_op_b, o_op_a} = w_head;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_overflow <= 1'b0;
        end else if (r_pvld && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    assign o_overflow = r_overflow;

`ifdef OPCOL_CONFLICT_CNT_EN
    logic [7:0] r_conflict_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_conflict_cnt <= '0;
        end else if (w_ser_b && r_conflict_cnt != 8'hFF) begin
            r_conflict_cnt <= r_conflict_cnt + 8'd1;
        end
    end

    assign o_conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_operand_collector.sv
// Self-checking bench for operand_collector: table-driven parallel fetches plus
// serial, protocol-error, backpressure and async-reset sequences, scoreboarded by queue.
`timescale 1ns/1ps
module tb_operand_collector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mar_load_a = 1'b0, mar_load_b = 1'b0;
    logic [3:0] mar_in_a = '0, mar_in_b = '0;
    logic       mem_oe_a = 1'b0, mem_oe_b = 1'b0;
    logic       stall = 1'b0;
    logic [7:0] rd_data_a = '0, rd_data_b = '0;
    logic       ops_ready = 1'b1;
    logic       ops_valid;
    logic [7:0] op_a, op_b;
    logic [3:0] op_addr;
    logic       overflow;
`ifdef OPCOL_CONFLICT_CNT_EN
    logic [7:0] conflict_cnt;
`endif

    operand_collector dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_mar_load_a (mar_load_a),
        .i_mar_in_a   (mar_in_a),
        .i_mar_load_b (mar_load_b),
        .i_mar_in_b   (mar_in_b),
        .i_mem_oe_a   (mem_oe_a),
        .i_mem_oe_b   (mem_oe_b),
        .i_stall      (stall),
        .i_rd_data_a  (rd_data_a),
        .i_rd_data_b  (rd_data_b),
        .i_ops_ready  (ops_ready),
        .o_ops_valid  (ops_valid),
        .o_op_a       (op_a),
        .o_op_b       (op_b),
        .o_op_addr    (op_addr),
        .o_overflow   (overflow)
`ifdef OPCOL_CONFLICT_CNT_EN
        ,
        .o_conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] addr;
    } pair_t;

    typedef struct packed {
        logic [3:0] ma;
        logic [3:0] mb;
        logic [7:0] da;
        logic [7:0] db;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [3:0] eaddr;
    } par_vec_t;

    pair_t exp_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_pair(input logic [7:0] a, input logic [7:0] b, input logic [3:0] addr);
        pair_t p;
        p.a    = a;
        p.b    = b;
        p.addr = addr;
        exp_q.push_back(p);
    endtask

    task automatic drive_req(input logic oa, input logic ob, input logic [3:0] ma, input logic [3:0] mb);
        @(negedge clk);
        mem_oe_a   = oa;
        mem_oe_b   = ob;
        mar_load_a = oa;
        mar_load_b = ob;
        mar_in_a   = ma;
        mar_in_b   = mb;
    endtask

    task automatic drive_data(input logic [7:0] da, input logic [7:0] db);
        @(negedge clk);
        mem_oe_a   = 1'b0;
        mem_oe_b   = 1'b0;
        mar_load_a = 1'b0;
        mar_load_b = 1'b0;
        rd_data_a  = da;
        rd_data_b  = db;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        @(negedge clk);
        check({name, "_valid_low"}, ops_valid, 1'b0);
    endtask

    // Scoreboard: every pair the consumer takes must be the oldest expected one.
    always @(negedge clk) begin
        if (!rst && ops_valid && ops_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pair: got a=0x%0h b=0x%0h addr=0x%0h, expected none",
                         op_a, op_b, op_addr);
            end else begin
                pair_t e;
                e = exp_q.pop_front();
                check("pair_op_a", op_a, e.a);
                check("pair_op_b", op_b, e.b);
                check("pair_op_addr", op_addr, e.addr);
            end
        end
    end

    par_vec_t   tv [6];
    logic [3:0] rma, rmb;
    logic [7:0] rda, rdb;
    logic       rsw;

    initial begin
        tv[0] = '{ma: 4'h4, mb: 4'h5, da: 8'h11, db: 8'h22, ea: 8'h11, eb: 8'h22, eaddr: 4'h4};
        tv[1] = '{ma: 4'h8, mb: 4'h7, da: 8'h33, db: 8'h44, ea: 8'h44, eb: 8'h33, eaddr: 4'h7};
        tv[2] = '{ma: 4'h0, mb: 4'hF, da: 8'h5A, db: 8'hA5, ea: 8'hA5, eb: 8'h5A, eaddr: 4'hF};
        tv[3] = '{ma: 4'hE, mb: 4'hF, da: 8'h01, db: 8'h02, ea: 8'h01, eb: 8'h02, eaddr: 4'hE};
        tv[4] = '{ma: 4'h3, mb: 4'h2, da: 8'hC3, db: 8'h3C, ea: 8'h3C, eb: 8'hC3, eaddr: 4'h2};
        tv[5] = '{ma: 4'hF, mb: 4'h0, da: 8'h77, db: 8'h88, ea: 8'h77, eb: 8'h88, eaddr: 4'hF};

        repeat (2) @(negedge clk);
        check("rst_ops_valid", ops_valid, 1'b0);
        check("rst_op_a", op_a, 8'h00);
        check("rst_op_b", op_b, 8'h00);
        check("rst_op_addr", op_addr, 4'h0);
        check("rst_overflow", overflow, 1'b0);
        rst = 1'b0;

        // First pair appears exactly MEM_LAT+1 cycles after the request edge.
        drive_req(1'b1, 1'b1, 4'h4, 4'h5);
        expect_pair(8'h11, 8'h22, 4'h4);
        drive_data(8'h11, 8'h22);
        @(negedge clk);
        check("lat_early", ops_valid, 1'b0);
        @(negedge clk);
        check("lat_on_time", ops_valid, 1'b1);
        wait_drain("lat");

        for (int i = 0; i < 6; i++) begin
            drive_req(1'b1, 1'b1, tv[i].ma, tv[i].mb);
            expect_pair(tv[i].ea, tv[i].eb, tv[i].eaddr);
            drive_data(tv[i].da, tv[i].db);
        end
        wait_drain("par_table");
        check("hold_op_a", op_a, 8'h77);
        check("hold_op_addr", op_addr, 4'hF);

        for (int i = 0; i < 6; i++) begin
            rma = 4'($urandom_range(0, 15));
            rsw = 1'($urandom_range(0, 1));
            rmb = rsw ? rma - 4'd1 : rma + 4'd1;
            rda = 8'($urandom_range(0, 255));
            rdb = 8'($urandom_range(0, 255));
            drive_req(1'b1, 1'b1, rma, rmb);
            expect_pair(rsw ? rdb : rda, rsw ? rda : rdb, rsw ? rmb : rma);
            drive_data(rda, rdb);
        end
        wait_drain("par_rand");

        // Serial fetch, both loads from bank A, with a gap cycle in between.
        stall = 1'b1;
        drive_req(1'b1, 1'b0, 4'h6, 4'h0);
        drive_data(8'h55, 8'h00);
        drive_req(1'b1, 1'b0, 4'h7, 4'h0);
        expect_pair(8'h55, 8'h66, 4'h6);
        drive_data(8'h66, 8'h00);
        stall = 1'b0;
        wait_drain("ser_aa");

        stall = 1'b1;
        drive_req(1'b0, 1'b1, 4'h0, 4'h9);
        drive_data(8'h00, 8'h12);
        drive_req(1'b1, 1'b0, 4'hA, 4'h0);
        expect_pair(8'h12, 8'h34, 4'h9);
        drive_data(8'h34, 8'h00);
        stall = 1'b0;
        wait_drain("ser_ba");

        // Both OEs while in SER1 abort the serial fetch; the next single OE starts afresh.
        drive_req(1'b1, 1'b0, 4'h2, 4'h0);
        drive_data(8'h99, 8'h00);
        drive_req(1'b1, 1'b1, 4'h4, 4'h5);
        drive_data(8'hE1, 8'hE2);
        drive_req(1'b1, 1'b0, 4'h3, 4'h0);
        drive_data(8'hAB, 8'h00);
        drive_req(1'b0, 1'b1, 4'h0, 4'h4);
        expect_pair(8'hAB, 8'hCD, 4'h3);
        drive_data(8'h00, 8'hCD);
        wait_drain("proto_err");

        ops_ready = 1'b0;
        drive_req(1'b1, 1'b1, 4'h2, 4'h3);
        expect_pair(8'h10, 8'h20, 4'h2);
        drive_data(8'h10, 8'h20);
        drive_req(1'b1, 1'b1, 4'h4, 4'h5);
        expect_pair(8'h30, 8'h40, 4'h4);
        drive_data(8'h30, 8'h40);
        drive_req(1'b1, 1'b1, 4'h6, 4'h7);
        drive_data(8'h50, 8'h60);
        repeat (3) @(negedge clk);
        check("bp_valid", ops_valid, 1'b1);
        check("bp_overflow", overflow, 1'b1);
        check("bp_head_a", op_a, 8'h10);
        ops_ready = 1'b1;
        wait_drain("backpressure");
        check("bp_overflow_sticky", overflow, 1'b1);

`ifdef OPCOL_CONFLICT_CNT_EN
        check("conflict_cnt", conflict_cnt, 8'd3);
`endif

        // Async reset between the two halves of a serial fetch.
        drive_req(1'b1, 1'b0, 4'h5, 4'h0);
        drive_data(8'hEE, 8'h00);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", ops_valid, 1'b0);
        check("arst_overflow", overflow, 1'b0);
        check("arst_op_a", op_a, 8'h00);
`ifdef OPCOL_CONFLICT_CNT_EN
        check("arst_conflict_cnt", conflict_cnt, 8'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        drive_req(1'b1, 1'b0, 4'h6, 4'h0);
        drive_data(8'hDD, 8'h00);
        repeat (6) @(negedge clk);
        check("arst_no_stale_pair", ops_valid, 1'b0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
